// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state encoding
// and the vector-count function used to size the expected truth table.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/sweep_hold_counter.sv
// Modulo-HOLD dwell counter; wrap pulses during the last cycle of each hold
// window so the owner can sample and advance on that same edge.
module sweep_hold_counter #(
  parameter int HOLD = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic wrap
);

  localparam int CNT_W = $clog2(HOLD) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector in binary order, holds
// each for HOLD cycles, and scores the DUT response against EXPECT.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                        N_IN        = 3,
  parameter int                        HOLD        = 20,
  parameter logic [n_vec(N_IN)-1:0]    EXPECT      = '0,
  parameter bit                        STOP_ON_ERR = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            f_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_valid
);

  localparam int              NV       = n_vec(N_IN);
  localparam int              ERR_W    = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(NV);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [N_IN-1:0]   fidx_q, fidx_d;
  logic              fval_q, fval_d;

  logic wrap;
  logic mismatch;

  // The dwell counter is held at zero outside APPLY, so a new sweep always
  // starts with a full hold window for vector 0.
  sweep_hold_counter #(
    .HOLD (HOLD)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != APPLY),
    .en    (state_q == APPLY),
    .wrap  (wrap)
  );

  assign mismatch = (f_in != EXPECT[vec_q]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fval_d  = fval_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          vec_d   = '0;
          err_d   = '0;
          fval_d  = 1'b0;
        end
      end

      APPLY: begin
        if (wrap) begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!fval_q) begin
              fidx_d = vec_q;
              fval_d = 1'b1;
            end
          end
          // vec_out freezes on the final or failing vector so it can be inspected.
          if ((vec_q == LAST_VEC) || (mismatch && STOP_ON_ERR)) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fval_q  <= fval_d;
    end
  end

  assign vec_out         = vec_q;
  assign busy            = (state_q == APPLY);
  assign done            = (state_q == DONE);
  assign pass            = (state_q == DONE) && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_idx   = fidx_q;
  assign first_err_valid = fval_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: three configured instances, with
// expected sweep outcomes queued at start and checked when done rises.
module tb_truth_table_sweeper;

  typedef struct {
    int   lat;
    logic pass;
    int   err;
    int   idx;
    logic fv;
    int   vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   sel;
  int   mode;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  logic start_a, start_b, start_c;
  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  logic [2:0] vec_a, fi_a, vec_b, fi_b;
  logic [3:0] err_a, err_b;
  logic       f_a, busy_a, done_a, pass_a, fv_a;
  logic       f_b, busy_b, done_b, pass_b, fv_b;
  logic [0:0] vec_c, fi_c;
  logic [1:0] err_c;
  logic       f_c, busy_c, done_c, pass_c, fv_c;

  assign f_a = (mode == 1) ? 1'b0 : ^vec_a;
  assign f_b = (^vec_b) ^ (vec_b == 3'd5);
  assign f_c = vec_c[0];

  truth_table_sweeper #(.N_IN(3), .HOLD(4), .EXPECT(8'b1001_0110), .STOP_ON_ERR(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .f_in(f_a), .vec_out(vec_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(fi_a), .first_err_valid(fv_a));

  truth_table_sweeper #(.N_IN(3), .HOLD(4), .EXPECT(8'b1001_0110), .STOP_ON_ERR(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .f_in(f_b), .vec_out(vec_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(fi_b), .first_err_valid(fv_b));

  truth_table_sweeper #(.N_IN(1), .HOLD(1), .EXPECT(2'b10), .STOP_ON_ERR(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .f_in(f_c), .vec_out(vec_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c), .first_err_idx(fi_c), .first_err_valid(fv_c));

  logic [31:0] o_vec, o_err, o_idx;
  logic        o_busy, o_done, o_pass, o_fv;

  always_comb begin
    o_vec = 32'(vec_a); o_err = 32'(err_a); o_idx = 32'(fi_a);
    o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_fv = fv_a;
    if (sel == 1) begin
      o_vec = 32'(vec_b); o_err = 32'(err_b); o_idx = 32'(fi_b);
      o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_fv = fv_b;
    end else if (sel == 2) begin
      o_vec = 32'(vec_c); o_err = 32'(err_c); o_idx = 32'(fi_c);
      o_busy = busy_c; o_done = done_c; o_pass = pass_c; o_fv = fv_c;
    end
  end

  function automatic exp_t mk(int lat, logic p, int err, int idx, logic fv, int vec);
    exp_t e;
    e.lat = lat; e.pass = p; e.err = err; e.idx = idx; e.fv = fv; e.vec = vec;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
    $display("check %s: observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".vec"}, o_vec, 0);
    chk({tag, ".busy"}, 32'(o_busy), 0);
    chk({tag, ".done"}, 32'(o_done), 0);
    chk({tag, ".pass"}, 32'(o_pass), 0);
    chk({tag, ".err"}, o_err, 0);
    chk({tag, ".idx"}, o_idx, 0);
    chk({tag, ".fv"}, 32'(o_fv), 0);
  endtask

  // Drives start for one edge (edge k) and checks the sweep-entry state.
  task automatic begin_sweep(input string tag, input bit push, input exp_t e);
    @(negedge clk);
    start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, ".start_busy"}, 32'(o_busy), 1);
    chk({tag, ".start_done"}, 32'(o_done), 0);
    chk({tag, ".start_vec"}, o_vec, 0);
    chk({tag, ".start_err"}, o_err, 0);
    chk({tag, ".start_fv"}, 32'(o_fv), 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // offset = number of edges already elapsed since edge k.
  task automatic wait_done(input string tag, input int offset);
    int   n;
    exp_t e;
    n = offset;
    while (o_done !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, ".latency"}, n, e.lat);
    chk({tag, ".busy"}, 32'(o_busy), 0);
    chk({tag, ".pass"}, 32'(o_pass), 32'(e.pass));
    chk({tag, ".err"}, o_err, e.err);
    chk({tag, ".fv"}, 32'(o_fv), 32'(e.fv));
    if (e.fv) chk({tag, ".idx"}, o_idx, e.idx);
    chk({tag, ".vec"}, o_vec, e.vec);
  endtask

  initial begin
    int t;
    sel = 0; mode = 0; rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_reset_values($sformatf("reset%0d", s));
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 0;

    // Clean XOR sweep, vector stepping, and a start re-pulse mid-sweep.
    begin_sweep("xor", 1'b1, mk(32, 1'b1, 0, 0, 1'b0, 7));
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("xor.vec_at_%0d", n), o_vec, n / 4);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("xor.repulse_vec", o_vec, 1);
    chk("xor.repulse_busy", 32'(o_busy), 1);
    wait_done("xor", 6);

    // Stuck-at-0 output: every vector whose expected F is 1 fails.
    mode = 1;
    begin_sweep("stuck0", 1'b1, mk(32, 1'b0, 4, 1, 1'b1, 7));
    wait_done("stuck0", 0);

    // Restart straight out of DONE with errors pending: counts must clear.
    mode = 0;
    begin_sweep("restart", 1'b1, mk(32, 1'b1, 0, 0, 1'b0, 7));
    wait_done("restart", 0);

    // Reset mid-sweep once vector 3 is on the bus.
    begin_sweep("midrst", 1'b0, mk(0, 1'b0, 0, 0, 1'b0, 0));
    t = 0;
    while (o_vec !== 32'd3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("midrst.reach_v3", o_vec, 3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    begin_sweep("after_rst", 1'b1, mk(32, 1'b1, 0, 0, 1'b0, 7));
    wait_done("after_rst", 0);

    // Simultaneous reset and start: reset wins.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_start.busy", 32'(o_busy), 0);
    chk("rst_start.done", 32'(o_done), 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;

    // Stop on first error at vector 5.
    sel = 1;
    begin_sweep("stop", 1'b1, mk(24, 1'b0, 1, 5, 1'b1, 5));
    wait_done("stop", 0);

    // Single-input, single-cycle hold.
    sel = 2;
    begin_sweep("hold1", 1'b1, mk(2, 1'b1, 0, 0, 1'b0, 1));
    @(posedge clk);
    #1;
    chk("hold1.vec_at_1", o_vec, 1);
    wait_done("hold1", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
